// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_seq
// Brief    : Iterative shift-add unsigned multiplier that borrows an external
//            32-bit ALU as its adder. One add per cycle, 32 iterations,
//            64-bit exact product.
// Options  : define ALU_MUL_SIGNED_EN to add a signed_i input (sign-magnitude
//            conversion at load, two's-complement fix-up at completion).
// Revision : 1.0  initial release
// ============================================================================
module alu_mul_seq #(
    parameter int         WIDTH    = 32,
    parameter int         CNT_W    = 6,
    parameter logic [3:0] ADD_CTRL = 4'b0010
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
`ifdef ALU_MUL_SIGNED_EN
    input  logic                 signed_i,
`endif
    input  logic [WIDTH-1:0]     mcand_i,
    input  logic [WIDTH-1:0]     mplier_i,
    output logic [WIDTH-1:0]     alu_src1_o,
    output logic [WIDTH-1:0]     alu_src2_o,
    output logic [3:0]           alu_ctrl_o,
    input  logic [WIDTH-1:0]     alu_result_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]           r_state;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_mcand;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_src1;
    logic [WIDTH-1:0]     w_src2;
    logic                 w_carry;
    logic [WIDTH-1:0]     w_mcand_load;
    logic [WIDTH-1:0]     w_mplier_load;
    logic [2*WIDTH-1:0]   w_final;

`ifdef ALU_MUL_SIGNED_EN
    logic                 r_neg;

    // Signed mode: load magnitudes and remember whether the result is negative
    always_comb begin
        w_mcand_load  = (signed_i && mcand_i[WIDTH-1])  ? (~mcand_i + 1'b1)  : mcand_i;
        w_mplier_load = (signed_i && mplier_i[WIDTH-1]) ? (~mplier_i + 1'b1) : mplier_i;
        w_final       = r_neg ? (~{r_hi, r_lo} + 1'b1) : {r_hi, r_lo};
    end

    // Sign flag captured with the accepted start
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_neg <= 1'b0;
        end else if (r_state == S_IDLE && start_i) begin
            r_neg <= signed_i & (mcand_i[WIDTH-1] ^ mplier_i[WIDTH-1]);
        end
    end
`else
    // Unsigned only: operands and result pass through untouched
    always_comb begin
        w_mcand_load  = mcand_i;
        w_mplier_load = mplier_i;
        w_final       = {r_hi, r_lo};
    end
`endif

    // ALU operands are only non-zero while iterating; the ALU has no
    // carry-out, so the sum's carry is rebuilt from the operand MSBs.
    always_comb begin
        w_src1  = '0;
        w_src2  = '0;
        if (r_state == S_CALC) begin
            w_src1 = r_hi;
            w_src2 = r_lo[0] ? r_mcand : '0;
        end
        w_carry = (w_src1[WIDTH-1] & w_src2[WIDTH-1]) |
                  ((w_src1[WIDTH-1] | w_src2[WIDTH-1]) & ~alu_result_i[WIDTH-1]);
    end

    // Control FSM and shift-add datapath
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= S_IDLE;
            r_hi      <= '0;
            r_lo      <= '0;
            r_mcand   <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_mcand <= w_mcand_load;
                        r_lo    <= w_mplier_load;
                        r_hi    <= '0;
                        r_cnt   <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    // {hi,lo} <= {carry, sum, lo[W-1:1]}
                    r_hi  <= {w_carry, alu_result_i[WIDTH-1:1]};
                    r_lo  <= {alu_result_i[0], r_lo[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_ITER) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_product <= w_final;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs: product is presented live during DONE and held afterwards
    always_comb begin
        alu_src1_o = w_src1;
        alu_src2_o = w_src2;
        alu_ctrl_o = ADD_CTRL;
        busy_o     = (r_state == S_CALC) || (r_state == S_DONE);
        done_o     = (r_state == S_DONE);
        product_o  = (r_state == S_DONE) ? w_final : r_product;
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mul_seq
// Brief    : Scoreboard bench for alu_mul_seq with a behavioural ALU model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_mul_seq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] mcand_i = '0;
    logic [31:0] mplier_i = '0;
    logic [31:0] alu_src1_o;
    logic [31:0] alu_src2_o;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] alu_result_i;
    logic        busy_o;
    logic        done_o;
    logic [63:0] product_o;

    int checks = 0;
    int failures = 0;
    int done_total = 0;
    int busy_cnt = 0;
    bit chk_src2_zero = 1'b0;
    logic [63:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    // External ALU: add only when the control code says add
    assign alu_result_i = (alu_ctrl_o == 4'b0010) ? (alu_src1_o + alu_src2_o) : 32'hDEAD_BEEF;

    alu_mul_seq dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
`ifdef ALU_MUL_SIGNED_EN
        .signed_i     (signed_i),
`endif
        .mcand_i      (mcand_i),
        .mplier_i     (mplier_i),
        .alu_src1_o   (alu_src1_o),
        .alu_src2_o   (alu_src2_o),
        .alu_ctrl_o   (alu_ctrl_o),
        .alu_result_i (alu_result_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .product_o    (product_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and tracks busy length
    always @(negedge clk_i) begin
        if (!rst_i) begin
            busy_cnt = 0;
        end else begin
            check("alu_ctrl", {60'd0, alu_ctrl_o}, 64'd2);
            if (busy_o) begin
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                check("busy_len", 64'(busy_cnt), 64'd33);
                busy_cnt = 0;
            end
            if (chk_src2_zero && busy_o) begin
                check("src2_zero", {32'd0, alu_src2_o}, 64'd0);
            end
            if (done_o) begin
                done_total++;
                check("done_busy", {63'd0, busy_o}, 64'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    check("product", product_o, exp_q.pop_front());
                end
            end
        end
    end

    // Issue one start pulse, optionally pushing an expected product
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input bit push, input logic [63:0] exp);
        @(negedge clk_i);
        mcand_i  = a;
        mplier_i = b;
        signed_i = s;
        start_i  = 1'b1;
        if (push) exp_q.push_back(exp);
        @(negedge clk_i);
        start_i  = 1'b0;
    endtask

    // Wait (bounded) for completion, then confirm the product is held
    task automatic wait_done(input logic [63:0] exp);
        int n = 0;
        while (!done_o && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        if (!done_o) check("done_timeout", 64'd0, 64'd1);
        repeat (3) @(negedge clk_i);
        check("product_held", product_o, exp);
        check("idle_done_low", {63'd0, done_o}, 64'd0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp);
        issue(a, b, s, 1'b1, exp);
        wait_done(exp);
    endtask

    initial begin
        int dones_before;
        // Reset state
        repeat (2) @(negedge clk_i);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_product", product_o, 64'd0);
        check("rst_src1", {32'd0, alu_src1_o}, 64'd0);
        check("rst_src2", {32'd0, alu_src2_o}, 64'd0);
        check("rst_ctrl", {60'd0, alu_ctrl_o}, 64'd2);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);

        run_op(32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
        run_op(32'd1, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_FFFF_FFFF);

        chk_src2_zero = 1'b1;
        run_op(32'd0, 32'h1234_5678, 1'b0, 64'd0);
        chk_src2_zero = 1'b0;

        // Second start while busy is ignored
        dones_before = done_total;
        issue(32'd7, 32'd9, 1'b0, 1'b1, 64'd63);
        repeat (8) @(negedge clk_i);
        issue(32'd2, 32'd2, 1'b0, 1'b0, 64'd0);
        wait_done(64'd63);
        repeat (40) @(negedge clk_i);
        check("single_done", 64'(done_total - dones_before), 64'd1);

        // Reset mid-operation
        dones_before = done_total;
        issue(32'd6, 32'd7, 1'b0, 1'b0, 64'd0);
        repeat (13) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        check("abort_done", {63'd0, done_o}, 64'd0);
        check("abort_product", product_o, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (40) @(negedge clk_i);
        check("abort_no_done", 64'(done_total - dones_before), 64'd0);
        run_op(32'd6, 32'd7, 1'b0, 64'd42);

`ifdef ALU_MUL_SIGNED_EN
        run_op(32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(32'hFFFF_FFFD, 32'hFFFF_FFF9, 1'b1, 64'd21);
`endif
        run_op(32'hFFFF_FFFD, 32'd7, 1'b0, 64'h0000_0006_FFFF_FFEB);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
